// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: data widths, the fetch FSM encoding and the
// reset vector used by the instruction fetch stage.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_chk.sv
// Protocol checks for the fetch stage: queue overflow, tag FIFO overflow and
// read responses arriving with nothing outstanding.
module if_stage_chk (
    input logic clk,
    input logic rst,
    input logic q_push,
    input logic q_full,
    input logic tag_push,
    input logic tag_full,
    input logic rvalid,
    input logic tag_empty
);

    // Sampled once per cycle outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(q_push && q_full));
            assert (!(tag_push && tag_full));
            assert (!(rvalid && tag_empty));
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with power-of-two depth; wrap-around is resolved by an extra
// pointer MSB so full and empty are distinguishable without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer next-state; flush empties the FIFO and overrides push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues in-order reads, tags them with their PC and
// queues returned instructions for decode; redirects flush and drain stale reads.
module if_stage
    import rv_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            inst_valid,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int TW = $clog2(MAX_OUTST) + 1;

    fetch_state_e          state_q, state_d;
    logic [$clog2(DEPTH):0] q_count_s;
    logic [TW-1:0]         outst_s;
    logic [TW-1:0]         outst_after_s;
    logic                  q_full_s, q_empty_s, t_full_s, t_empty_s;
    logic [XLEN+ILEN-1:0]  q_rdata_s;
    logic [XLEN-1:0]       tag_head_s;
    logic                  grant_s, resp_s, q_push_s, q_pop_s;

    assign grant_s       = imem_req && imem_gnt;
    // Responses with nothing outstanding are ignored.
    assign resp_s        = imem_rvalid && !t_empty_s;
    assign q_push_s      = resp_s && (state_q == RUN) && !redirect;
    assign q_pop_s       = inst_valid && inst_ready;
    assign outst_after_s = outst_s + TW'(grant_s) - TW'(resp_s);
    assign imem_addr     = pc_addr;

    assign inst_valid = rst && !q_empty_s;
    assign inst_data  = inst_valid ? q_rdata_s[ILEN-1:0] : '0;
    assign inst_pc    = inst_valid ? q_rdata_s[XLEN+ILEN-1:ILEN] : '0;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a redirect with reads still in flight must drain them first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect && (outst_after_s != '0)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (outst_after_s == '0) begin
                    state_d = RUN;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: request throttling and the next PC.
    always_comb begin
        imem_req = 1'b0;
        pc_next  = pc_addr;
        if (rst && (state_q == RUN)) begin
            imem_req = ((32'(q_count_s) + 32'(outst_s)) < 32'(DEPTH)) &&
                       (32'(outst_s) < 32'(MAX_OUTST));
        end else begin
            imem_req = 1'b0;
        end
        if (!rst) begin
            pc_next = RESET_VECTOR;
        end else if (redirect) begin
            pc_next = align_word(redirect_addr);
        end else if (grant_s) begin
            pc_next = pc_addr + 32'(INST_BYTES);
        end else begin
            pc_next = pc_addr;
        end
    end

    sync_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (q_push_s),
        .pop   (q_pop_s),
        .wdata ({tag_head_s, imem_rdata}),
        .rdata (q_rdata_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

    // The tag FIFO occupancy is the outstanding-read count.
    sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (grant_s),
        .pop   (resp_s),
        .wdata (pc_addr),
        .rdata (tag_head_s),
        .full  (t_full_s),
        .empty (t_empty_s),
        .count (outst_s)
    );

    if_stage_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .q_push    (q_push_s),
        .q_full    (q_full_s),
        .tag_push  (grant_s),
        .tag_full  (t_full_s),
        .rvalid    (imem_rvalid),
        .tag_empty (t_empty_s)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the bench plays PC register and instruction
// memory (rdata = addr + 32'h1000_0000) and checks hand-derived values.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr, pc_next, imem_addr, imem_rdata, redirect_addr, inst_data, inst_pc;
    logic        imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          grants;
    bit          gnt_en, resp_en;
    logic [31:0] pend[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_data[$];
    logic [31:0] obs_pc, obs_next, obs_addr, obs_data, obs_ipc;
    logic        obs_req, obs_valid;

    always #5 clk = ~clk;

    if_stage #(.DEPTH(4), .MAX_OUTST(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // One clock cycle: drive at negedge, observe just after, update models after posedge.
    task automatic cyc();
        logic g;
        @(negedge clk);
        imem_gnt = gnt_en;
        if (resp_en && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0] + 32'h1000_0000;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        obs_pc    = pc_addr;
        obs_next  = pc_next;
        obs_addr  = imem_addr;
        obs_req   = imem_req;
        obs_valid = inst_valid;
        obs_data  = inst_data;
        obs_ipc   = inst_pc;
        g = imem_req && imem_gnt;
        if (inst_valid && inst_ready) begin
            got_pc.push_back(inst_pc);
            got_data.push_back(inst_data);
        end
        @(posedge clk);
        if (imem_rvalid) void'(pend.pop_front());
        if (g) begin
            pend.push_back(obs_pc);
            grants++;
        end
        #1 pc_addr = obs_next;
    endtask

    initial begin
        rst = 1'b0; pc_addr = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_addr = 32'h0; inst_ready = 1'b1;
        gnt_en = 1'b1; resp_en = 1'b1; grants = 0;

        // Reset state
        cyc(); cyc();
        chk("rst_req", 32'(obs_req), 32'h0);
        chk("rst_pc_next", obs_next, 32'h0);
        chk("rst_valid", 32'(obs_valid), 32'h0);
        chk("rst_data", obs_data, 32'h0);
        chk("rst_ipc", obs_ipc, 32'h0);

        // First request in the second cycle after release
        rst = 1'b1;
        cyc();
        chk("idle_req", 32'(obs_req), 32'h0);
        cyc();
        chk("first_req", 32'(obs_req), 32'h1);
        chk("first_addr", obs_addr, 32'h0);
        chk("first_next", obs_next, 32'h4);

        // Steady stream
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("stream_next", obs_next, obs_pc + 32'h4);
        end
        gnt_en = 1'b0;
        repeat (3) cyc();
        chk("stream_count", 32'(got_pc.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk("stream_pc", got_pc[i], 32'(i * 4));
            chk("stream_data", got_data[i], 32'(i * 4) + 32'h1000_0000);
        end

        // Backpressure: decode stalled, exactly DEPTH grants
        got_pc.delete(); got_data.delete();
        inst_ready = 1'b0; gnt_en = 1'b1; grants = 0;
        repeat (7) cyc();
        chk("bp_grants", 32'(grants), 32'd4);
        chk("bp_req", 32'(obs_req), 32'h0);
        chk("bp_hold", obs_next, 32'h34);
        chk("bp_valid", 32'(obs_valid), 32'h1);
        chk("bp_head_pc", obs_ipc, 32'h24);
        chk("bp_head_data", obs_data, 32'h1000_0024);
        grants = 0;
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        cyc();
        chk("pulse_req", 32'(obs_req), 32'h1);
        cyc(); cyc();
        chk("pulse_grants", 32'(grants), 32'd1);
        chk("pulse_req_after", 32'(obs_req), 32'h0);
        chk("pulse_deliv", 32'(got_pc.size()), 32'd1);
        chk("pulse_pc", got_pc[0], 32'h24);
        got_pc.delete(); got_data.delete();
        inst_ready = 1'b1; gnt_en = 1'b0;
        repeat (5) cyc();
        chk("bp_drain_cnt", 32'(got_pc.size()), 32'd4);
        chk("bp_drain_last", got_pc[3], 32'h34);

        // Redirect with one queued entry and two reads outstanding
        got_pc.delete(); got_data.delete();
        inst_ready = 1'b0; resp_en = 1'b1; gnt_en = 1'b1;
        cyc(); cyc();
        resp_en = 1'b0;
        cyc(); cyc();
        chk("rd_blocked_req", 32'(obs_req), 32'h0);
        chk("rd_pre_valid", 32'(obs_valid), 32'h1);
        redirect = 1'b1; redirect_addr = 32'h0000_0103;
        cyc();
        chk("rd_next", obs_next, 32'h0000_0100);
        redirect = 1'b0; resp_en = 1'b1; inst_ready = 1'b1;
        cyc();
        chk("rd_drain_req", 32'(obs_req), 32'h0);
        chk("rd_flushed", 32'(obs_valid), 32'h0);
        cyc(); cyc();
        chk("rd_restart_req", 32'(obs_req), 32'h1);
        chk("rd_restart_addr", obs_addr, 32'h0000_0100);
        gnt_en = 1'b0;
        repeat (3) cyc();
        chk("rd_deliv_cnt", 32'(got_pc.size()), 32'd1);
        chk("rd_deliv_pc", got_pc[0], 32'h0000_0100);
        chk("rd_pending", 32'(pend.size()), 32'd0);

        // Redirect and grant in the same cycle at pc 32'h40
        got_pc.delete(); got_data.delete();
        redirect = 1'b1; redirect_addr = 32'h40; gnt_en = 1'b0;
        cyc();
        redirect_addr = 32'h200; gnt_en = 1'b1;
        cyc();
        chk("rg_req", 32'(obs_req), 32'h1);
        chk("rg_pc", obs_pc, 32'h40);
        chk("rg_next", obs_next, 32'h200);
        redirect = 1'b0; gnt_en = 1'b0;
        cyc();
        chk("rg_drain_req", 32'(obs_req), 32'h0);
        gnt_en = 1'b1;
        cyc();
        gnt_en = 1'b0;
        repeat (3) cyc();
        chk("rg_deliv_cnt", 32'(got_pc.size()), 32'd1);
        chk("rg_deliv_pc", got_pc[0], 32'h200);

        // Grant withheld for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("gw_req", 32'(obs_req), 32'h1);
            chk("gw_hold", obs_next, obs_pc);
            chk("gw_addr", obs_addr, 32'h204);
        end

        // Reset with three queued entries and one read outstanding
        inst_ready = 1'b0; gnt_en = 1'b1; resp_en = 1'b1;
        repeat (4) cyc();
        chk("mr_pre_valid", 32'(obs_valid), 32'h1);
        chk("mr_pre_ipc", obs_ipc, 32'h204);
        rst = 1'b0; resp_en = 1'b0; gnt_en = 1'b0;
        cyc();
        chk("mr_next_now", obs_next, 32'h0);
        cyc();
        chk("mr_valid", 32'(obs_valid), 32'h0);
        chk("mr_data", obs_data, 32'h0);
        chk("mr_ipc", obs_ipc, 32'h0);
        chk("mr_req", 32'(obs_req), 32'h0);
        chk("mr_next", obs_next, 32'h0);
        pend.delete();
        rst = 1'b1;
        cyc();
        chk("mr_idle_req", 32'(obs_req), 32'h0);
        cyc();
        chk("mr_restart_req", 32'(obs_req), 32'h1);
        chk("mr_restart_addr", obs_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries, power of two, minimum 2.
REQ-002 Parameter MAX_OUTST, default 2: maximum granted-but-unanswered memory reads.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 pc_addr  in  32  current PC register value.
REQ-006 pc_next  out  32  next PC value, registered by the PC register every cycle.
REQ-007 imem_req  out  1  read request to instruction memory.
REQ-008 imem_addr  out  32  read address; equals pc_addr.
REQ-009 imem_gnt  in  1  request accepted this cycle.
REQ-010 imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after grant.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 redirect  in  1  branch/jump taken; flush and restart.
REQ-013 redirect_addr  in  32  restart address.
REQ-014 inst_valid  out  1  queue head valid to decode.
REQ-015 inst_data  out  32  head instruction.
REQ-016 inst_pc  out  32  head instruction address.
REQ-017 inst_ready  in  1  decode accepts head; transfer occurs when inst_valid and inst_ready are both 1.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN; IDLE → RUN unconditionally after one cycle.
REQ-019 In RUN, imem_req is 1 iff (queue count + outstanding) < DEPTH and outstanding < MAX_OUTST; imem_req is 0 in IDLE and DRAIN.
REQ-020 pc_next is computed combinationally:
  - redirect_addr with bits [1:0] forced to 0 when redirect=1;
  - else pc_addr+4, modulo 2^32, when imem_req and imem_gnt are both 1;
  - else pc_addr.
REQ-021 Each grant pushes pc_addr into an in-order tag FIFO of depth MAX_OUTST and increments outstanding.
REQ-022 Each imem_rvalid pops one tag and decrements outstanding; in RUN, {tag, imem_rdata} is written to the queue tail.
REQ-023 The instruction queue is a FIFO: first-word latency is 1 cycle from rvalid to inst_valid; a simultaneous push and pop keeps the count unchanged; wrap-around uses a pointer MSB.
REQ-024 Queue overflow is impossible by the REQ-019 accounting; a push to a full queue is an assertion failure.
REQ-025 inst_data and inst_pc hold stable while inst_valid=1 and inst_ready=0.
REQ-026 Redirect in any state:
  - queue flushed next cycle, so inst_valid=0;
  - if outstanding after this cycle's grant/response > 0 → DRAIN, else → RUN.
REQ-027 Redirect and grant in the same cycle: redirect wins pc_next, and the granted read counts as outstanding and is discarded.
REQ-028 In DRAIN, every response is discarded (tag popped, no queue write); DRAIN → RUN in the cycle after outstanding reaches 0.
REQ-029 A redirect during DRAIN stays in DRAIN, updates pc_next, and leaves the outstanding count unchanged.
REQ-030 imem_rvalid with outstanding=0 is a protocol error and is ignored (assertion).

Reset
REQ-031 While rst=0:
  - FSM=IDLE, queue count=0, outstanding=0, tag FIFO empty;
  - inst_valid=0, imem_req=0, pc_next=32'h0, inst_data=0, inst_pc=0.
REQ-032 Reset mid-operation drops all queued and in-flight state; responses arriving after reset with outstanding=0 follow REQ-030.
REQ-033 The first request is issued in the second cycle after rst rises, at pc_addr=0.

Structure
REQ-034 Shared package rv_pkg holds XLEN=32, ILEN=32, INST_BYTES=4, the fetch-state enum (IDLE/RUN/DRAIN) and RESET_VECTOR=32'h0.
REQ-035 One sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count) is instantiated twice: instruction queue with WIDTH=64, tag FIFO with WIDTH=32.

Verification
REQ-036 Steady stream: gnt=1 every cycle, rvalid 1 cycle later, ready=1 → inst_pc = 0,4,8,12… and pc_next = pc_addr+4 each cycle.
REQ-037 Backpressure: ready=0, DEPTH=4 → exactly 4 grants, then imem_req=0 and pc_next=pc_addr held; one ready pulse → one new request.
REQ-038 Redirect to 32'h0000_0103 with 2 outstanding → pc_next=32'h0000_0100, queue empty next cycle, both stale responses dropped, first delivered inst_pc=32'h100.
REQ-039 Redirect and gnt in the same cycle at pc=32'h40 → pc_next=redirect target, and the 32'h40 response is discarded.
REQ-040 gnt withheld 3 cycles → pc_next=pc_addr for 3 cycles, imem_addr stable.
REQ-041 rst=0 asserted while queue holds 3 entries and 1 read is outstanding → all outputs zero next cycle; after release, fetch restarts at 32'h0.
